// File: rtl/motor_encoder_emulator_if.sv
// -----------------------------------------------------------------------------
// motor_encoder_emulator_if
//
// Purpose: groups the motor-header signals of one emulated motor. The
// embedded system (or a bench) drives direction and PWM enable, and the
// emulator returns quadrature outputs plus its observability counters.
//
// Signal semantics: there is no valid/ready handshake on this interface.
// Every signal is a plain level. motor_dir/motor_en may change at any time
// and asynchronously to clk. All emulator outputs are registered and change
// only on the rising edge of the emulator clock.
//
// Ports / signals:
//   motor_dir  master->slave  1 = forward, 0 = reverse
//   motor_en   master->slave  PWM enable
//   enc_a      slave->master  quadrature channel A
//   enc_b      slave->master  quadrature channel B
//   step       slave->master  one-cycle pulse on every A/B transition
//   position   slave->master  signed 32-bit step count
//   duty_meas  slave->master  high cycles in the last completed window
//   rate       slave->master  current phase-accumulator increment
//
// Parameter WIN_BITS must match the emulator instance it is connected to.
// -----------------------------------------------------------------------------
interface motor_encoder_emulator_if #(
  parameter int WIN_BITS = 12
);
  logic                motor_dir;
  logic                motor_en;
  logic                enc_a;
  logic                enc_b;
  logic                step;
  logic [31:0]         position;
  logic [WIN_BITS:0]   duty_meas;
  logic [WIN_BITS:0]   rate;

  // Embedded-system side: drives the motor header, reads the encoder.
  modport master (
    output motor_dir,
    output motor_en,
    input  enc_a,
    input  enc_b,
    input  step,
    input  position,
    input  duty_meas,
    input  rate
  );

  // Emulator side.
  modport slave (
    input  motor_dir,
    input  motor_en,
    output enc_a,
    output enc_b,
    output step,
    output position,
    output duty_meas,
    output rate
  );
endinterface

// File: rtl/motor_encoder_emulator.sv
// -----------------------------------------------------------------------------
// motor_encoder_emulator
//
// Purpose: hardware-in-the-loop model of one DC motor with a quadrature
// encoder. The PWM enable is measured over a fixed window of 2^WIN_BITS
// cycles; the measured duty becomes the increment of a phase accumulator
// whose carry produces one quadrature step. Loop enc_a/enc_b back to the
// encoder inputs of the system under test.
//
// Parameters:
//   WIN_BITS  duty window is 2^WIN_BITS clk cycles
//   ACC_W     phase accumulator width, must be > WIN_BITS+1
//   RAMP_STEP largest rate change per window end (inertia build only)
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high; clears all state
//   bus    motor_encoder_emulator_if.slave (motor_dir, motor_en in;
//          enc_a, enc_b, step, position, duty_meas, rate out)
//
// Build option:
//   MOTOR_EMU_INERTIA_EN  when defined, rate slews toward the measured duty
//                         by at most RAMP_STEP per window end instead of
//                         jumping straight to it.
// -----------------------------------------------------------------------------
module motor_encoder_emulator #(
  parameter int WIN_BITS  = 12,
  parameter int ACC_W     = 24,
  parameter int RAMP_STEP = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  motor_encoder_emulator_if.slave      bus
);

  localparam int RW = WIN_BITS + 1;

  // A full-on rate of 2^WIN_BITS must stay below half the accumulator range
  // so that at most one carry (one step) can happen per cycle.
  generate
    if (ACC_W <= WIN_BITS + 1 || RAMP_STEP < 1) begin : g_bad_params
      $error("motor_encoder_emulator: need ACC_W > WIN_BITS+1 and RAMP_STEP >= 1");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                en_m, en_s;
  logic                dir_m, dir_s;
  logic [WIN_BITS-1:0] win_cnt;
  logic [RW-1:0]       hi_cnt;
  logic [RW-1:0]       duty_q;
  logic [RW-1:0]       rate_q;
  logic [ACC_W-1:0]    acc;
  logic [1:0]          q;
  logic                enc_a_q;
  logic                enc_b_q;
  logic                step_q;
  logic [31:0]         pos_q;

  // ---------------------------------------------------------------------------
  // Next-state helpers
  // ---------------------------------------------------------------------------
  logic                win_end;
  logic [RW-1:0]       duty_next;
  logic [RW-1:0]       rate_next;
  logic [ACC_W:0]      acc_sum;
  logic                carry;
  logic [1:0]          q_next;

  always_comb begin
    win_end   = &win_cnt;
    // Count of high cycles including the current one; at window end this is
    // the finished measurement, otherwise it is the running count.
    duty_next = hi_cnt + {{WIN_BITS{1'b0}}, en_s};
    acc_sum   = {1'b0, acc} + {{(ACC_W - WIN_BITS){1'b0}}, rate_q};
    carry     = acc_sum[ACC_W];
    // Direction is only looked at when a step is actually taken, so a
    // direction change between steps never skips a quadrature state.
    q_next    = q;
    if (carry) begin
      q_next = dir_s ? (q + 2'd1) : (q - 2'd1);
    end
  end

`ifdef MOTOR_EMU_INERTIA_EN
  // Clip the ramp to the largest possible rate so it fits the rate width.
  localparam int            RAMP_CLIP = (RAMP_STEP > (1 << WIN_BITS)) ? (1 << WIN_BITS) : RAMP_STEP;
  localparam logic [RW-1:0] RAMP      = RAMP_CLIP[RW-1:0];

  // Slew toward the new measurement; differences are taken in the direction
  // that cannot underflow, and the add/subtract only happens when the target
  // is farther away than RAMP, so the result never passes the target.
  always_comb begin
    rate_next = duty_next;
    if (duty_next > rate_q) begin
      if ((duty_next - rate_q) > RAMP) begin
        rate_next = rate_q + RAMP;
      end
    end else begin
      if ((rate_q - duty_next) > RAMP) begin
        rate_next = rate_q - RAMP;
      end
    end
  end
`else
  assign rate_next = duty_next;
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      en_m    <= 1'b0;
      en_s    <= 1'b0;
      dir_m   <= 1'b0;
      dir_s   <= 1'b0;
      win_cnt <= '0;
      hi_cnt  <= '0;
      duty_q  <= '0;
      rate_q  <= '0;
      acc     <= '0;
      q       <= 2'd0;
      enc_a_q <= 1'b0;
      enc_b_q <= 1'b0;
      step_q  <= 1'b0;
      pos_q   <= 32'd0;
    end else begin
      // Two-flop synchronizers for the asynchronous motor header inputs.
      en_m  <= bus.motor_en;
      en_s  <= en_m;
      dir_m <= bus.motor_dir;
      dir_s <= dir_m;

      // Free-running window; wraps naturally at all-ones.
      win_cnt <= win_cnt + 1'b1;

      if (win_end) begin
        duty_q <= duty_next;
        rate_q <= rate_next;
        hi_cnt <= '0;
      end else begin
        hi_cnt <= duty_next;
      end

      // The rate in use on this edge is the old one; a rate updated at
      // window end is first added on the following cycle.
      acc    <= acc_sum[ACC_W-1:0];
      step_q <= carry;

      // Outputs move on the same edge as the accumulator wrap.
      if (carry) begin
        q       <= q_next;
        // q 0,1,2,3 -> {A,B} 00,10,11,01
        enc_a_q <= q_next[1] ^ q_next[0];
        enc_b_q <= q_next[1];
        pos_q   <= dir_s ? (pos_q + 32'd1) : (pos_q - 32'd1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.enc_a     = enc_a_q;
  assign bus.enc_b     = enc_b_q;
  assign bus.step      = step_q;
  assign bus.position  = pos_q;
  assign bus.duty_meas = duty_q;
  assign bus.rate      = rate_q;

endmodule

// File: tb/tb_motor_encoder_emulator.sv
// -----------------------------------------------------------------------------
// tb_motor_encoder_emulator
//
// Bench for motor_encoder_emulator at WIN_BITS=4, ACC_W=8, RAMP_STEP=4.
// A behavioural model of the motor (cycle counter, integer phase, integer
// position) runs beside the design; each scenario task drives the motor
// header and compares against the model and against fixed expected values.
// Build with +define+MOTOR_EMU_INERTIA_EN to include the inertia scenario.
// -----------------------------------------------------------------------------
module tb_motor_encoder_emulator;

  localparam int WB      = 4;
  localparam int AW      = 8;
  localparam int RS      = 4;
  localparam int W1      = WB + 1;
  localparam int WIN     = 1 << WB;
  localparam int ACC_MOD = 1 << AW;
  localparam int VW      = 2 + 1 + 32 + W1 + W1;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  motor_encoder_emulator_if #(.WIN_BITS(WB)) bus ();

  motor_encoder_emulator #(
    .WIN_BITS (WB),
    .ACC_W    (AW),
    .RAMP_STEP(RS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  // ---------------------------------------------------------------------------
  // Reference model: the motor as arithmetic on integers.
  // ---------------------------------------------------------------------------
  int          m_phase = 0;
  int          m_rate  = 0;
  int          m_duty  = 0;
  int          m_hi    = 0;
  int          m_cyc   = 0;
  int          m_en_m  = 0;
  int          m_en_s  = 0;
  int          m_dir_m = 0;
  int          m_dir_s = 0;
  logic [31:0] m_pos   = 32'd0;
  logic        m_step  = 1'b0;

  function automatic logic [1:0] enc_of(input logic [31:0] p);
    case (p[1:0])
      2'd0:    return 2'b00;
      2'd1:    return 2'b10;
      2'd2:    return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  always @(posedge clk) begin : model
    if (reset) begin
      m_phase = 0; m_rate = 0; m_duty = 0; m_hi = 0; m_cyc = 0;
      m_en_m = 0; m_en_s = 0; m_dir_m = 0; m_dir_s = 0;
      m_pos = 32'd0; m_step = 1'b0;
    end else begin
      int sum;
      int diff;
      sum    = m_phase + m_rate;
      m_step = (sum >= ACC_MOD);
      if (m_step) m_pos = (m_dir_s != 0) ? m_pos + 32'd1 : m_pos - 32'd1;
      m_phase = sum % ACC_MOD;
      if (m_cyc == WIN - 1) begin
        m_duty = m_hi + m_en_s;
        m_hi   = 0;
`ifdef MOTOR_EMU_INERTIA_EN
        diff = m_duty - m_rate;
        if (diff > RS) diff = RS;
        if (diff < -RS) diff = -RS;
        m_rate = m_rate + diff;
`else
        diff   = 0;
        m_rate = m_duty + diff;
`endif
      end else begin
        m_hi = m_hi + m_en_s;
      end
      m_cyc   = (m_cyc + 1) % WIN;
      m_en_s  = m_en_m;
      m_en_m  = int'(bus.motor_en);
      m_dir_s = m_dir_m;
      m_dir_m = int'(bus.motor_dir);
    end
  end

  function automatic logic [VW-1:0] model_vec();
    logic [W1-1:0] d;
    logic [W1-1:0] r;
    d = m_duty[W1-1:0];
    r = m_rate[W1-1:0];
    return {enc_of(m_pos), m_step, m_pos, d, r};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {bus.enc_a, bus.enc_b, bus.step, bus.position, bus.duty_meas, bus.rate};
  endfunction

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    bus.motor_en = 1'b1; bus.motor_dir = 1'b1; reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (dut_vec() !== {VW{1'b0}}) begin
      errors++; $display("FAIL reset_values: got %h expected 0", dut_vec());
    end
    reset = 1'b0;
    for (int i = 0; i < WIN; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.enc_a, bus.enc_b, bus.step, bus.position} !== 35'd0) begin
        errors++; $display("FAIL reset_no_motion cyc %0d: got pos=%h step=%b", i, bus.position, bus.step);
      end
      if (i < WIN - 1) begin
        checks++;
        if (bus.rate !== '0) begin
          errors++; $display("FAIL reset_rate_early cyc %0d: got %0d expected 0", i, bus.rate);
        end
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL reset_model cyc %0d: dut=%h model=%h", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_full_on();
    logic [1:0]  seq [4];
    logic [31:0] prev;
    int          n;
    seq  = '{2'b10, 2'b11, 2'b01, 2'b00};
    prev = 32'd0;
    n    = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL full_on_model cyc %0d: dut=%h model=%h", i, dut_vec(), model_vec());
      end
      if (m_cyc == 0) begin
        checks++;
        if (bus.duty_meas !== 5'd16 || bus.rate !== 5'd16) begin
          errors++; $display("FAIL full_on_window: duty=%0d rate=%0d expected 16/16", bus.duty_meas, bus.rate);
        end
      end
      if (bus.step === 1'b1) begin
        checks++;
        if (bus.position !== prev + 32'd1 || {bus.enc_a, bus.enc_b} !== seq[n % 4]) begin
          errors++; $display("FAIL full_on_step %0d: pos=%h ab=%b expected pos=%h ab=%b",
                             n, bus.position, {bus.enc_a, bus.enc_b}, prev + 32'd1, seq[n % 4]);
        end
        prev = prev + 32'd1;
        n++;
      end
    end
    checks++;
    if (n < 4) begin
      errors++; $display("FAIL full_on_step_count: got %0d expected >= 4", n);
    end
  endtask

  task automatic test_quarter();
    int win_idx;
    int nsteps;
    int last_k;
    win_idx = 0; nsteps = 0; last_k = 0;
    @(negedge clk);
    reset = 1'b1; bus.motor_dir = 1'b1; bus.motor_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k < 320; k++) begin
      bus.motor_en = ((k % WIN) < 4);
      @(negedge clk);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL quarter_model cyc %0d: dut=%h model=%h", k, dut_vec(), model_vec());
      end
      if (m_cyc == 0) begin
        win_idx++;
        if (win_idx >= 2) begin
          checks++;
          if (bus.duty_meas !== 5'd4) begin
            errors++; $display("FAIL quarter_duty win %0d: got %0d expected 4", win_idx, bus.duty_meas);
          end
        end
      end
      if (bus.step === 1'b1) begin
        nsteps++;
        if (nsteps >= 3) begin
          checks++;
          if (k - last_k != 64) begin
            errors++; $display("FAIL quarter_interval: got %0d expected 64", k - last_k);
          end
        end
        last_k = k;
      end
    end
    checks++;
    if (nsteps < 3) begin
      errors++; $display("FAIL quarter_step_count: got %0d expected >= 3", nsteps);
    end
  endtask

  task automatic test_reverse();
    logic [31:0] exp_pos [3];
    logic [1:0]  exp_ab  [3];
    logic [31:0] base;
    int          n;
    bit          seen;
    exp_pos = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD};
    exp_ab  = '{2'b01, 2'b11, 2'b10};
    n = 0;
    @(negedge clk);
    reset = 1'b1; bus.motor_en = 1'b1; bus.motor_dir = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL reverse_model cyc %0d: dut=%h model=%h", i, dut_vec(), model_vec());
      end
      if (bus.step === 1'b1) begin
        if (n < 3) begin
          checks++;
          if (bus.position !== exp_pos[n] || {bus.enc_a, bus.enc_b} !== exp_ab[n]) begin
            errors++; $display("FAIL reverse_step %0d: pos=%h ab=%b expected pos=%h ab=%b",
                               n, bus.position, {bus.enc_a, bus.enc_b}, exp_pos[n], exp_ab[n]);
          end
        end
        n++;
      end
    end
    // Flip direction right after a step; only the next step reverses.
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = (m_step == 1'b1);
    end
    base = m_pos;
    bus.motor_dir = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL flip_model cyc %0d: dut=%h model=%h", i, dut_vec(), model_vec());
      end
      if (bus.step === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (bus.position !== base + 32'd1 || {bus.enc_a, bus.enc_b} !== enc_of(base + 32'd1)) begin
          errors++; $display("FAIL flip_step: pos=%h ab=%b expected pos=%h ab=%b",
                             bus.position, {bus.enc_a, bus.enc_b}, base + 32'd1, enc_of(base + 32'd1));
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL flip_timeout: got no step expected one within 40 cycles");
    end
  endtask

  task automatic test_stop();
    logic [31:0] hold_pos;
    bus.motor_en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL stop_model cyc %0d: dut=%h model=%h", i, dut_vec(), model_vec());
      end
    end
    hold_pos = m_pos;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      checks++;
      if (bus.step !== 1'b0 || bus.rate !== '0 || bus.position !== hold_pos ||
          {bus.enc_a, bus.enc_b} !== enc_of(hold_pos)) begin
        errors++; $display("FAIL stop_hold cyc %0d: step=%b rate=%0d pos=%h expected 0/0/%h",
                           i, bus.step, bus.rate, bus.position, hold_pos);
      end
    end
  endtask

  task automatic test_reset_mid();
    int run;
    run = 60 + $urandom_range(0, 20);
    bus.motor_en = 1'b1; bus.motor_dir = 1'b1;
    for (int i = 0; i < run; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL reset_mid_model cyc %0d: dut=%h model=%h", i, dut_vec(), model_vec());
      end
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (dut_vec() !== {VW{1'b0}}) begin
      errors++; $display("FAIL reset_mid: got %h expected 0", dut_vec());
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    int d;
    int ph;
    for (int w = 0; w < 90; w++) begin
      d  = $urandom_range(0, WIN);
      ph = $urandom_range(0, WIN - 1);
      if ($urandom_range(0, 3) == 0) bus.motor_dir = ~bus.motor_dir;
      for (int j = 0; j < WIN; j++) begin
        bus.motor_en = (((j + ph) % WIN) < d);
        reset = ($urandom_range(0, 399) == 0);
        @(negedge clk);
        checks++;
        if (dut_vec() !== model_vec()) begin
          errors++; $display("FAIL random_model win %0d cyc %0d: dut=%h model=%h", w, j, dut_vec(), model_vec());
        end
      end
    end
    reset = 1'b0;
  endtask

`ifdef MOTOR_EMU_INERTIA_EN
  task automatic test_inertia();
    int exp_rate [8];
    int win;
    exp_rate = '{4, 8, 12, 16, 12, 8, 4, 0};
    win = 0;
    @(negedge clk);
    reset = 1'b1; bus.motor_en = 1'b1; bus.motor_dir = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL inertia_model cyc %0d: dut=%h model=%h", i, dut_vec(), model_vec());
      end
      if (m_cyc == 0 && win < 8) begin
        checks++;
        if (int'(bus.rate) != exp_rate[win]) begin
          errors++; $display("FAIL inertia_rate win %0d: got %0d expected %0d", win + 1, bus.rate, exp_rate[win]);
        end
        win++;
        if (win == 4) bus.motor_en = 1'b0;
      end
    end
    checks++;
    if (win < 8) begin
      errors++; $display("FAIL inertia_windows: got %0d expected 8", win);
    end
  endtask
`endif

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    bus.motor_en  = 1'b0;
    bus.motor_dir = 1'b0;
    test_reset();
    test_full_on();
    test_quarter();
    test_reverse();
    test_stop();
    test_reset_mid();
    test_random();
`ifdef MOTOR_EMU_INERTIA_EN
    test_inertia();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish within 2 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
